wired_cdb_bank_sched: RTL and testbench
=======================================

// Module: wired_cdb_bank_sched
// PURPOSE
//  Schedules result write-back from the backend functional units (ALU IQ ports, LSU IQ port) onto the two CDB slots.
//  CDB slot b carries only results whose ROB id has wid[0]==b, matching the banked ROB/forwarding lookup (cdb[rreg[0]]).
//  Per-bank round-robin grant, registered CDB output, flush squash and a saturating contention counter.
//  Sits between the IQ cdb_o/cdb_ready_i ports and the ROB/IQ/forwarding consumers of cdb.
// PARAMETERS
//  PORT_CNT    3   number of requesting producers (2 ALU + 1 LSU), >=2
//  ROB_LEN     6   ROB id width (`_WIRED_PARAM_ROB_LEN); bit 0 selects the bank
//  DATA_WIDTH  32  result data width
// PORTS
//  clk          in   1                     clock, all state on rising edge
//  rst_n        in   1                     asynchronous active-low reset
//  flush_i      in   1                     pipeline flush from commit
//  req_valid_i  in   PORT_CNT              producer p has a result
//  req_wid_i    in   PORT_CNT x ROB_LEN    destination ROB id of producer p
//  req_wdata_i  in   PORT_CNT x DATA_WIDTH result data of producer p
//  req_ready_o  out  PORT_CNT              grant; transfer when valid&ready
//  cdb_valid_o  out  2                     CDB slot b valid
//  cdb_wid_o    out  2 x ROB_LEN           CDB slot b ROB id (bit0 == b when valid)
//  cdb_wdata_o  out  2 x DATA_WIDTH        CDB slot b data
//  conflict_o   out  16                    cycles with at least one valid request not granted
// BEHAVIOUR
//  Reset (async, rst_n=0): cdb_valid_o=0, cdb_wid_o=0, cdb_wdata_o=0, conflict_o=0, rr_ptr[0]=rr_ptr[1]=0.
//   req_ready_o is combinational and is 0 while rst_n=0.
//  Eligibility: cand[b][p] = req_valid_i[p] && req_wid_i[p][0]==b && !flush_i.
//  Grant per bank: first eligible p scanning rr_ptr[b], rr_ptr[b]+1, ... mod PORT_CNT. One grant per bank per cycle.
//   A port can be granted only in the bank of its own wid, so at most 2 ports are granted per cycle.
//   req_ready_o[p] = OR over b of gnt[b][p]. It is combinational in the same cycle and does not depend on req_ready_o.
//  Latency: the granted request appears on cdb_*_o[b] exactly 1 cycle later, registered.
//   If bank b has no grant, cdb_valid_o[b]=0 next cycle. wid/wdata hold their last value (don't-care while valid=0).
//  No backpressure from consumers: the CDB always sinks.
//  Pointer: on grant to port p in bank b, rr_ptr[b] <= (p==PORT_CNT-1) ? 0 : p+1. Otherwise rr_ptr[b] holds.
//   Fairness: a port holding valid in bank b is granted within PORT_CNT cycles.
//  Producers must keep valid/wid/wdata stable until accepted. The arbiter keeps no request state.
//  Flush: flush_i=1 -> all req_ready_o=0 that cycle; cdb_valid_o<=0 next cycle; rr_ptr and conflict_o unchanged.
//   An output already registered in the cycle of the flush is still visible during that cycle.
//  conflict_o: +1 in any non-flush cycle where some req_valid_i[p]=1 and req_ready_o[p]=0.
//   Saturates at 16'hFFFF. Cleared only by reset.
//  Simultaneous events: both banks may grant in the same cycle. A bank-0 and a bank-1 grant never block each other.
//  Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). Pending requests are not
//   granted until rst_n deasserts; the first grant uses rr_ptr=0.
// TESTING
//  T1 reset: drive rst_n=0 mid-stream with valid requests -> cdb_valid_o=2'b00, conflict_o=0, req_ready_o=0 in the same cycle.
//  T2 single: port1 wid=6'h05, data=32'hDEADBEEF for 1 cycle -> req_ready_o=3'b010 that cycle; next cycle
//   cdb_valid_o=2'b10, cdb_wid_o[1]=6'h05, cdb_wdata_o[1]=32'hDEADBEEF.
//  T3 dual-bank: port0 wid=6'h02, port2 wid=6'h03 together -> req_ready_o=3'b101;
//   next cycle both slots valid with the matching data; conflict_o unchanged.
//  T4 round-robin wrap: ports 0,1,2 hold wid 6'h00/6'h04/6'h08 continuously -> grant order 0,1,2,0,1,...;
//   rr_ptr[0] wraps 2->0; conflict_o +1 every cycle.
//  T5 flush: port0 valid and flush_i=1 for 1 cycle -> req_ready_o=0, cdb_valid_o=0 next cycle;
//   port0 granted in the following cycle.
//  T6 saturation: hold a 2-port same-bank conflict for 70000 cycles -> conflict_o stays at 16'hFFFF and does not wrap to 0.

Source files
------------

// File: rtl/wired_cdb_bank_sched_if.sv
// Producer-to-CDB bus for the write-back scheduler: request handshake from the
// functional units on one side, the two banked CDB slots on the other.
interface wired_cdb_bank_sched_if #(
    parameter int PORT_CNT   = 3,
    parameter int ROB_LEN    = 6,
    parameter int DATA_WIDTH = 32
);
    logic [PORT_CNT-1:0]                 req_valid_i;
    logic [PORT_CNT-1:0][ROB_LEN-1:0]    req_wid_i;
    logic [PORT_CNT-1:0][DATA_WIDTH-1:0] req_wdata_i;
    logic [PORT_CNT-1:0]                 req_ready_o;
    logic [1:0]                          cdb_valid_o;
    logic [1:0][ROB_LEN-1:0]             cdb_wid_o;
    logic [1:0][DATA_WIDTH-1:0]          cdb_wdata_o;

    // Producers / CDB consumers side
    modport master (
        output req_valid_i, req_wid_i, req_wdata_i,
        input  req_ready_o, cdb_valid_o, cdb_wid_o, cdb_wdata_o
    );

    // Scheduler side
    modport slave (
        input  req_valid_i, req_wid_i, req_wdata_i,
        output req_ready_o, cdb_valid_o, cdb_wid_o, cdb_wdata_o
    );
endinterface

// File: rtl/wired_cdb_bank_sched.sv
// CDB write-back scheduler. Each ROB bank (wid[0]) owns one CDB slot and a
// round-robin arbiter; the winner of each bank is registered onto its slot.
// Flush squashes grants without disturbing fairness state or the counter.

// Per-bank round-robin arbiter: scans from rr_ptr upward, one grant per cycle.
module wired_cdb_bank_arb #(
    parameter int PORT_CNT = 3,
    parameter int PTR_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PORT_CNT-1:0] cand,
    output logic [PORT_CNT-1:0] gnt,
    output logic                gnt_any
);
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt;
    int               idx;

    // First candidate at or after rr_ptr (wrapping) wins; pointer moves past it.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        ptr_nxt = rr_ptr;
        idx     = 0;
        for (int i = 0; i < PORT_CNT; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= PORT_CNT) idx = idx - PORT_CNT;
            if (!gnt_any && cand[idx]) begin
                gnt[idx] = 1'b1;
                gnt_any  = 1'b1;
                ptr_nxt  = (idx == PORT_CNT - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    // Pointer only advances on a grant, so a squashed cycle keeps the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= ptr_nxt;
    end
endmodule

module wired_cdb_bank_sched #(
    parameter int PORT_CNT   = 3,
    parameter int ROB_LEN    = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    wired_cdb_bank_sched_if.slave  bus,
    output logic [15:0]            conflict_o
);
    localparam int PTR_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;

    typedef struct packed {
        logic [ROB_LEN-1:0]    wid;
        logic [DATA_WIDTH-1:0] wdata;
    } cdb_ent_t;

    logic [1:0][PORT_CNT-1:0] cand;
    logic [1:0][PORT_CNT-1:0] gnt;
    logic [1:0]               gnt_any;
    logic [PORT_CNT-1:0]      ready;
    cdb_ent_t [1:0]           sel;
    cdb_ent_t [1:0]           cdb_q;
    logic [1:0]               vld_q;
    logic                     lose;
    logic [15:0]              conf_q;

    // A request is only eligible in the bank named by its ROB id; reset and
    // flush mask everything so no grant (and no pointer move) can happen.
    always_comb begin
        cand = '0;
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < PORT_CNT; p++) begin
                cand[b][p] = rst_n && !flush_i && bus.req_valid_i[p]
                             && (bus.req_wid_i[p][0] == 1'(b));
            end
        end
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        wired_cdb_bank_arb #(
            .PORT_CNT (PORT_CNT),
            .PTR_W    (PTR_W)
        ) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .cand    (cand[gb]),
            .gnt     (gnt[gb]),
            .gnt_any (gnt_any[gb])
        );

        assign bus.cdb_wid_o[gb]   = cdb_q[gb].wid;
        assign bus.cdb_wdata_o[gb] = cdb_q[gb].wdata;
    end

    // Grants are one-hot per bank, so a plain priority select is a clean mux.
    always_comb begin
        sel = '0;
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < PORT_CNT; p++) begin
                if (gnt[b][p]) begin
                    sel[b].wid   = bus.req_wid_i[p];
                    sel[b].wdata = bus.req_wdata_i[p];
                end
            end
        end
    end

    // A port can win in at most one bank (its own), so OR-ing the banks is safe.
    always_comb begin
        ready = gnt[0] | gnt[1];
        lose  = !flush_i && (|(bus.req_valid_i & ~ready));
    end

    assign bus.req_ready_o = ready;
    assign bus.cdb_valid_o = vld_q;
    assign conflict_o      = conf_q;

    // CDB slot register; payload only loads on a grant and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cdb_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                vld_q[b] <= gnt_any[b];
                if (gnt_any[b]) cdb_q[b] <= sel[b];
            end
        end
    end

    // Saturating count of cycles where some valid producer was left waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         conf_q <= '0;
        else if (lose && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
    end
endmodule

// File: tb/tb_wired_cdb_bank_sched.sv
// Scoreboard bench for the CDB write-back scheduler: a behavioural model of the
// banked round-robin predicts grants each cycle and queues the CDB contents
// expected one cycle later.
module tb_wired_cdb_bank_sched;
    localparam int P  = 3;
    localparam int RL = 6;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]          v;
        logic [1:0][RL-1:0]  wid;
        logic [1:0][DW-1:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] conflict;

    wired_cdb_bank_sched_if #(.PORT_CNT(P), .ROB_LEN(RL), .DATA_WIDTH(DW)) bus ();

    wired_cdb_bank_sched #(.PORT_CNT(P), .ROB_LEN(RL), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .bus        (bus.slave),
        .conflict_o (conflict)
    );

    always #5 clk = ~clk;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          m_ptr[2];
    int unsigned m_conf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [RL-1:0] w, input logic [DW-1:0] d);
        bus.req_valid_i[p] = v;
        bus.req_wid_i[p]   = w;
        bus.req_wdata_i[p] = d;
    endtask

    task automatic model_reset();
        m_ptr[0] = 0;
        m_ptr[1] = 0;
        m_conf   = 0;
        sbq.delete();
    endtask

    // One clock: predict this cycle's grants, check ready, queue the CDB
    // expectation, then after the edge pop and check the registered slots.
    task automatic step();
        exp_t           e;
        logic [P-1:0]   rdy;
        int             idx;
        e   = '0;
        rdy = '0;
        #1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < P; i++) begin
                idx = (m_ptr[b] + i) % P;
                if (!e.v[b] && rst_n && !flush && bus.req_valid_i[idx]
                    && bus.req_wid_i[idx][0] == 1'(b)) begin
                    e.v[b]    = 1'b1;
                    e.wid[b]  = bus.req_wid_i[idx];
                    e.data[b] = bus.req_wdata_i[idx];
                    rdy[idx]  = 1'b1;
                    m_ptr[b]  = (idx + 1) % P;
                end
            end
        end
        chk("ready", 64'(bus.req_ready_o), 64'(rdy));
        if (rst_n && !flush && |(bus.req_valid_i & ~rdy) && m_conf < 32'hFFFF) m_conf++;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sbq_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk("cdb_valid", 64'(bus.cdb_valid_o), 64'(e.v));
            for (int b = 0; b < 2; b++) begin
                if (e.v[b]) begin
                    chk($sformatf("cdb_wid%0d", b), 64'(bus.cdb_wid_o[b]), 64'(e.wid[b]));
                    chk($sformatf("cdb_data%0d", b), 64'(bus.cdb_wdata_o[b]), 64'(e.data[b]));
                end
            end
        end
        chk("conflict", 64'(conflict), 64'(m_conf));
    endtask

    initial begin
        logic [15:0] conf_save;
        logic [P-1:0] exp_rdy;
        bus.req_valid_i = '0;
        bus.req_wid_i   = '0;
        bus.req_wdata_i = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("rst_wid", 64'(bus.cdb_wid_o), 64'd0);
        chk("rst_conf", 64'(conflict), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T2 single request on bank 1
        set_port(1, 1'b1, 6'h05, 32'hDEADBEEF);
        #1 chk("t2_ready", 64'(bus.req_ready_o), 64'b010);
        step();
        set_port(1, 1'b0, 6'h00, 32'h0);
        chk("t2_valid", 64'(bus.cdb_valid_o), 64'b10);
        chk("t2_wid", 64'(bus.cdb_wid_o[1]), 64'h05);
        chk("t2_data", 64'(bus.cdb_wdata_o[1]), 64'hDEADBEEF);

        // T3 both banks in one cycle
        conf_save = conflict;
        set_port(0, 1'b1, 6'h02, 32'h1111_2222);
        set_port(2, 1'b1, 6'h03, 32'h3333_4444);
        #1 chk("t3_ready", 64'(bus.req_ready_o), 64'b101);
        step();
        set_port(0, 1'b0, 6'h00, 32'h0);
        set_port(2, 1'b0, 6'h00, 32'h0);
        chk("t3_valid", 64'(bus.cdb_valid_o), 64'b11);
        chk("t3_data0", 64'(bus.cdb_wdata_o[0]), 64'h1111_2222);
        chk("t3_data1", 64'(bus.cdb_wdata_o[1]), 64'h3333_4444);
        chk("t3_conf", 64'(conflict), 64'(conf_save));
        step();

        // T1 async reset in the middle of contended traffic
        set_port(0, 1'b1, 6'h00, 32'hA000_0000);
        set_port(1, 1'b1, 6'h04, 32'hA000_0001);
        set_port(2, 1'b1, 6'h08, 32'hA000_0002);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("t1_conf", 64'(conflict), 64'd0);
        chk("t1_ready", 64'(bus.req_ready_o), 64'd0);
        @(posedge clk);
        #1 chk("t1_ready_hold", 64'(bus.req_ready_o), 64'd0);
        #2 rst_n = 1'b1;

        // T4 round-robin wrap from pointer 0
        for (int k = 0; k < 7; k++) begin
            exp_rdy = P'(1) << (k % 3);
            #1 chk("t4_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
            step();
            chk("t4_wid", 64'(bus.cdb_wid_o[0]), 64'(6'(4 * (k % 3))));
            chk("t4_conf", 64'(conflict), 64'(k + 1));
        end

        // T5 flush squashes a grant, retried next cycle
        set_port(1, 1'b0, 6'h00, 32'h0);
        set_port(2, 1'b0, 6'h00, 32'h0);
        conf_save = conflict;
        flush = 1'b1;
        #1 chk("t5_ready", 64'(bus.req_ready_o), 64'd0);
        step();
        flush = 1'b0;
        chk("t5_valid", 64'(bus.cdb_valid_o), 64'd0);
        chk("t5_conf", 64'(conflict), 64'(conf_save));
        #1 chk("t5_regrant", 64'(bus.req_ready_o), 64'b001);
        step();
        chk("t5_valid2", 64'(bus.cdb_valid_o), 64'b01);

        // T6 counter saturation under a held same-bank conflict
        set_port(1, 1'b1, 6'h04, 32'hB000_0001);
        for (int k = 0; k < 70000; k++) step();
        chk("t6_sat", 64'(conflict), 64'hFFFF);
        set_port(0, 1'b0, 6'h00, 32'h0);
        set_port(1, 1'b0, 6'h00, 32'h0);
        step();
        step();
        chk("t6_sat_hold", 64'(conflict), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
